bottling_fill_controller: RTL and testbench

Consumer side of the target settings: latches the target bottle count and pills-per-bottle count produced by the settings logic, then runs the fill sequence. It counts pills from the dispenser sensor, drives the dispense valve, requests bottle changes and reports progress. It sits between the settings/display logic and the conveyor/dispenser I/O, and its 2-bit state code drives the display's standard/setting/report selection.

---
 rtl/bottling_fill_controller_pkg.sv | 12 +
 rtl/bottling_fill_controller_pill_edge_sync.sv | 28 ++
 rtl/bottling_fill_controller.sv | 152 +++++++++++++++
 tb/tb_bottling_fill_controller.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bottling_fill_controller_pkg.sv
// Shared settings package: display state codes and default counter widths
// used by the bottling fill controller and the settings/display logic.
package bottling_fill_controller_pkg;

  localparam int CNT_W_DEF = 6;
  localparam int TOT_W_DEF = 12;

  localparam logic [1:0] S_ZERO_CODE   = 2'b00;
  localparam logic [1:0] S_OPER_CODE   = 2'b01;
  localparam logic [1:0] S_REPORT_CODE = 2'b11;

endpackage

// File: rtl/bottling_fill_controller_pill_edge_sync.sv
// Three-flop synchronizer for an asynchronous level input, producing a
// one-cycle pulse on each synchronized rising edge.
module pill_edge_sync (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic rise
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= sync_d;
    end
  end

  // sync_q[1] is the second synchronizer stage; sync_q[2] delays it once more.
  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/bottling_fill_controller.sv
// Fill sequencer: latches bottle/pill targets on start, counts sensor pills,
// drives the dispense valve and requests a conveyor step per full bottle.
module bottling_fill_controller
  import bottling_fill_controller_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TOT_W = TOT_W_DEF
) (
  input  logic             in_CLK,
  input  logic             in_RST,
  input  logic             in_start,
  input  logic             in_clear,
  input  logic [CNT_W-1:0] in_target_bottle_num,
  input  logic [CNT_W-1:0] in_target_pill_num,
  input  logic             in_pill,
  input  logic             in_bottle_ready,
  output logic [1:0]       out_state,
  output logic             out_valve_open,
  output logic             out_bottle_advance,
  output logic [CNT_W-1:0] out_cur_pills,
  output logic [CNT_W-1:0] out_done_bottles,
  output logic [TOT_W-1:0] out_total_pills,
  output logic             out_error
);

  localparam logic [1:0] ST_ZERO   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_SWAP   = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] tgt_bottles_q, tgt_bottles_d;
  logic [CNT_W-1:0] tgt_pills_q, tgt_pills_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             error_q, error_d;
  logic             advance_q, advance_d;

  logic             pill_rise;
  logic [CNT_W-1:0] cur_inc;

  pill_edge_sync u_pill_sync (
    .clk  (in_CLK),
    .srst (in_RST),
    .din  (in_pill),
    .rise (pill_rise)
  );

  assign cur_inc = cur_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    tgt_bottles_d = tgt_bottles_q;
    tgt_pills_d   = tgt_pills_q;
    cur_d         = cur_q;
    done_d        = done_q;
    total_d       = total_q;
    error_d       = error_q;
    advance_d     = 1'b0;

    if (in_clear) begin
      // Targets stay latched; only progress and the fault flag are wiped.
      state_d = ST_ZERO;
      cur_d   = '0;
      done_d  = '0;
      total_d = '0;
      error_d = 1'b0;
    end else begin
      case (state_q)
        ST_ZERO: begin
          if (in_start) begin
            tgt_bottles_d = in_target_bottle_num;
            tgt_pills_d   = in_target_pill_num;
            if ((in_target_bottle_num == '0) || (in_target_pill_num == '0)) begin
              state_d = ST_REPORT;
              error_d = 1'b1;
            end else begin
              state_d = ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (pill_rise) begin
            cur_d   = cur_inc;
            total_d = total_q + TOT_W'(1);
            if (cur_inc == tgt_pills_q) begin
              done_d    = done_q + CNT_W'(1);
              advance_d = 1'b1;
              state_d   = ST_SWAP;
            end
          end
        end
        ST_SWAP: begin
          if (pill_rise) begin
            error_d = 1'b1;
          end
          // The conveyor cannot have moved while the advance pulse is still out.
          if (in_bottle_ready && !advance_q) begin
            if (done_q == tgt_bottles_q) begin
              state_d = ST_REPORT;
            end else begin
              cur_d   = '0;
              state_d = ST_FILL;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      state_q       <= ST_ZERO;
      tgt_bottles_q <= '0;
      tgt_pills_q   <= '0;
      cur_q         <= '0;
      done_q        <= '0;
      total_q       <= '0;
      error_q       <= 1'b0;
      advance_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_bottles_q <= tgt_bottles_d;
      tgt_pills_q   <= tgt_pills_d;
      cur_q         <= cur_d;
      done_q        <= done_d;
      total_q       <= total_d;
      error_q       <= error_d;
      advance_q     <= advance_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_ZERO:   out_state = S_ZERO_CODE;
      ST_REPORT: out_state = S_REPORT_CODE;
      default:   out_state = S_OPER_CODE;
    endcase
  end

  assign out_valve_open     = (state_q == ST_FILL);
  assign out_bottle_advance = advance_q;
  assign out_cur_pills      = cur_q;
  assign out_done_bottles   = done_q;
  assign out_total_pills    = total_q;
  assign out_error          = error_q;

endmodule

// File: tb/tb_bottling_fill_controller.sv
// Scenario bench for bottling_fill_controller; bottle-advance events are
// checked against a queue of expected (done, total) pairs.
module tb_bottling_fill_controller;

  logic        in_CLK = 1'b0;
  logic        in_RST = 1'b1;
  logic        in_start = 1'b0;
  logic        in_clear = 1'b0;
  logic [5:0]  in_target_bottle_num = '0;
  logic [5:0]  in_target_pill_num = '0;
  logic        in_pill = 1'b0;
  logic        in_bottle_ready = 1'b0;
  logic [1:0]  out_state;
  logic        out_valve_open;
  logic        out_bottle_advance;
  logic [5:0]  out_cur_pills;
  logic [5:0]  out_done_bottles;
  logic [11:0] out_total_pills;
  logic        out_error;

  int checks = 0;
  int failures = 0;
  int adv_count = 0;
  logic [17:0] exp_q[$];

  always #5 in_CLK = ~in_CLK;

  bottling_fill_controller #(.CNT_W(6), .TOT_W(12)) dut (
    .in_CLK               (in_CLK),
    .in_RST               (in_RST),
    .in_start             (in_start),
    .in_clear             (in_clear),
    .in_target_bottle_num (in_target_bottle_num),
    .in_target_pill_num   (in_target_pill_num),
    .in_pill              (in_pill),
    .in_bottle_ready      (in_bottle_ready),
    .out_state            (out_state),
    .out_valve_open       (out_valve_open),
    .out_bottle_advance   (out_bottle_advance),
    .out_cur_pills        (out_cur_pills),
    .out_done_bottles     (out_done_bottles),
    .out_total_pills      (out_total_pills),
    .out_error            (out_error)
  );

  // Advance monitor: pops one expected (done,total) pair per advance pulse.
  initial begin
    logic prev_adv;
    logic [17:0] e;
    prev_adv = 1'b0;
    forever begin
      @(negedge in_CLK);
      if (out_bottle_advance) begin
        adv_count++;
        checks++;
        if (prev_adv !== 1'b0) begin
          failures++;
          $display("FAIL adv_width: advance high 2+ cycles, required 1-cycle pulse");
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL adv_unexpected: advance with done=%0d total=%0d, none expected",
                   out_done_bottles, out_total_pills);
        end else begin
          e = exp_q.pop_front();
          if ({out_done_bottles, out_total_pills} !== e) begin
            failures++;
            $display("FAIL adv_counts: done=%0d total=%0d, required done=%0d total=%0d",
                     out_done_bottles, out_total_pills, e[17:12], e[11:0]);
          end else begin
            $display("advance: done=%0d total=%0d ok", out_done_bottles, out_total_pills);
          end
        end
      end
      prev_adv = out_bottle_advance;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge in_CLK);
  endtask

  task automatic pulse();
    in_pill = 1'b1;
    tick(2);
    in_pill = 1'b0;
    tick(2);
  endtask

  task automatic clear_pulse();
    in_clear = 1'b1;
    tick(1);
    in_clear = 1'b0;
  endtask

  task automatic start(input int b, input int p);
    in_target_bottle_num = 6'(b);
    in_target_pill_num   = 6'(p);
    in_start = 1'b1;
    tick(1);
    in_start = 1'b0;
  endtask

  task automatic ready2();
    in_bottle_ready = 1'b1;
    tick(2);
    in_bottle_ready = 1'b0;
  endtask

  task automatic test_reset();
    in_RST = 1'b1;
    tick(2);
    checks++;
    if ({out_state, out_valve_open, out_bottle_advance} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: state=%b valve=%b adv=%b, required 00/0/0",
               out_state, out_valve_open, out_bottle_advance);
    end
    checks++;
    if ({out_cur_pills, out_done_bottles, out_total_pills, out_error} !== 25'd0) begin
      failures++;
      $display("FAIL reset_cnt: cur=%0d done=%0d total=%0d err=%b, required zeros",
               out_cur_pills, out_done_bottles, out_total_pills, out_error);
    end
    in_RST = 1'b0;
    tick(1);
    $display("reset: state=%b", out_state);
  endtask

  task automatic test_fill_2x3();
    int a0;
    bit seen;
    clear_pulse();
    a0 = adv_count;
    start(2, 3);
    checks++;
    if (out_state !== 2'b01 || out_valve_open !== 1'b1) begin
      failures++;
      $display("FAIL start_oper: state=%b valve=%b, required 01/1", out_state, out_valve_open);
    end
    for (int b = 0; b < 2; b++) begin
      pulse();
      pulse();
      exp_q.push_back({6'(b + 1), 12'((b + 1) * 3)});
      in_pill = 1'b1;
      tick(2);
      in_pill = 1'b0;
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
        if (out_bottle_advance) seen = 1;
        else tick(1);
      end
      checks++;
      if (!seen || out_valve_open !== 1'b0) begin
        failures++;
        $display("FAIL adv_wait: seen=%0d valve=%b, required advance with valve 0", seen, out_valve_open);
      end
      in_bottle_ready = 1'b1;
      tick(1);
      checks++;
      if (out_cur_pills !== 6'd3 || out_state !== 2'b01) begin
        failures++;
        $display("FAIL ready_same_cycle: cur=%0d state=%b, required 3/01 (ready ignored)",
                 out_cur_pills, out_state);
      end
      tick(1);
      checks++;
      if (b == 0) begin
        if (out_cur_pills !== 6'd0 || out_valve_open !== 1'b1) begin
          failures++;
          $display("FAIL swap_refill: cur=%0d valve=%b, required 0/1", out_cur_pills, out_valve_open);
        end
      end else if (out_state !== 2'b11) begin
        failures++;
        $display("FAIL swap_report: state=%b, required 11", out_state);
      end
      in_bottle_ready = 1'b0;
    end
    checks++;
    if (out_total_pills !== 12'd6 || out_done_bottles !== 6'd2 || out_error !== 1'b0 ||
        out_valve_open !== 1'b0) begin
      failures++;
      $display("FAIL fill_2x3_final: total=%0d done=%0d err=%b valve=%b, required 6/2/0/0",
               out_total_pills, out_done_bottles, out_error, out_valve_open);
    end
    checks++;
    if (adv_count - a0 !== 2) begin
      failures++;
      $display("FAIL fill_2x3_advs: pulses=%0d, required 2", adv_count - a0);
    end
    $display("fill_2x3: total=%0d done=%0d state=%b", out_total_pills, out_done_bottles, out_state);
  endtask

  task automatic test_zero_target();
    bit opened;
    clear_pulse();
    start(2, 0);
    checks++;
    if (out_state !== 2'b11 || out_error !== 1'b1) begin
      failures++;
      $display("FAIL zero_pill_tgt: state=%b err=%b, required 11/1", out_state, out_error);
    end
    opened = out_valve_open;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (out_valve_open) opened = 1;
    end
    checks++;
    if (opened !== 1'b0) begin
      failures++;
      $display("FAIL zero_valve: valve opened=%0d, required 0", opened);
    end
    clear_pulse();
    start(0, 5);
    checks++;
    if (out_state !== 2'b11 || out_error !== 1'b1 || out_valve_open !== 1'b0) begin
      failures++;
      $display("FAIL zero_bottle_tgt: state=%b err=%b valve=%b, required 11/1/0",
               out_state, out_error, out_valve_open);
    end
    $display("zero_target: state=%b err=%b", out_state, out_error);
  endtask

  task automatic test_overfill();
    clear_pulse();
    start(1, 4);
    for (int i = 0; i < 3; i++) pulse();
    exp_q.push_back({6'd1, 12'd4});
    pulse();
    pulse();
    checks++;
    if (out_cur_pills !== 6'd4 || out_total_pills !== 12'd4 || out_error !== 1'b1 ||
        out_state !== 2'b01) begin
      failures++;
      $display("FAIL overfill: cur=%0d total=%0d err=%b state=%b, required 4/4/1/01",
               out_cur_pills, out_total_pills, out_error, out_state);
    end
    ready2();
    checks++;
    if (out_state !== 2'b11 || out_error !== 1'b1) begin
      failures++;
      $display("FAIL overfill_report: state=%b err=%b, required 11/1", out_state, out_error);
    end
    $display("overfill: cur=%0d total=%0d err=%b", out_cur_pills, out_total_pills, out_error);
  endtask

  task automatic test_full_63();
    clear_pulse();
    start(63, 63);
    for (int b = 0; b < 63; b++) begin
      for (int p = 0; p < 62; p++) pulse();
      exp_q.push_back({6'(b + 1), 12'((b + 1) * 63)});
      pulse();
      ready2();
    end
    checks++;
    if (out_total_pills !== 12'd3969 || out_done_bottles !== 6'd63 || out_state !== 2'b11 ||
        out_error !== 1'b0) begin
      failures++;
      $display("FAIL full_63: total=%0d done=%0d state=%b err=%b, required 3969/63/11/0",
               out_total_pills, out_done_bottles, out_state, out_error);
    end
    $display("full_63: total=%0d done=%0d", out_total_pills, out_done_bottles);
  endtask

  task automatic test_clear_mid();
    clear_pulse();
    start(3, 5);
    pulse();
    pulse();
    checks++;
    if (out_cur_pills !== 6'd2 || out_total_pills !== 12'd2) begin
      failures++;
      $display("FAIL mid_count: cur=%0d total=%0d, required 2/2", out_cur_pills, out_total_pills);
    end
    // Third pill edge lands on the same clock edge as in_clear.
    in_pill = 1'b1;
    tick(2);
    in_pill = 1'b0;
    in_clear = 1'b1;
    tick(1);
    in_clear = 1'b0;
    checks++;
    if ({out_state, out_valve_open, out_bottle_advance, out_cur_pills, out_done_bottles,
         out_total_pills, out_error} !== 29'd0) begin
      failures++;
      $display("FAIL clear_mid: state=%b valve=%b cur=%0d done=%0d total=%0d err=%b, required zeros",
               out_state, out_valve_open, out_cur_pills, out_done_bottles, out_total_pills, out_error);
    end
    tick(2);
    checks++;
    if (out_total_pills !== 12'd0) begin
      failures++;
      $display("FAIL clear_edge_discard: total=%0d, required 0", out_total_pills);
    end
    start(1, 2);
    exp_q.push_back({6'd1, 12'd2});
    pulse();
    pulse();
    ready2();
    checks++;
    if (out_state !== 2'b11 || out_total_pills !== 12'd2 || out_error !== 1'b0) begin
      failures++;
      $display("FAIL clear_restart: state=%b total=%0d err=%b, required 11/2/0",
               out_state, out_total_pills, out_error);
    end
    $display("clear_mid: restart total=%0d", out_total_pills);
  endtask

  task automatic test_reset_mid();
    clear_pulse();
    start(2, 3);
    pulse();
    in_RST = 1'b1;
    tick(1);
    checks++;
    if ({out_state, out_valve_open, out_bottle_advance, out_cur_pills, out_done_bottles,
         out_total_pills, out_error} !== 29'd0) begin
      failures++;
      $display("FAIL reset_mid: state=%b valve=%b cur=%0d total=%0d err=%b, required zeros",
               out_state, out_valve_open, out_cur_pills, out_total_pills, out_error);
    end
    in_RST = 1'b0;
    tick(1);
    start(1, 1);
    exp_q.push_back({6'd1, 12'd1});
    pulse();
    ready2();
    checks++;
    if (out_state !== 2'b11 || out_done_bottles !== 6'd1 || out_total_pills !== 12'd1) begin
      failures++;
      $display("FAIL reset_restart: state=%b done=%0d total=%0d, required 11/1/1",
               out_state, out_done_bottles, out_total_pills);
    end
    $display("reset_mid: restart done=%0d", out_done_bottles);
  endtask

  task automatic test_target_change();
    clear_pulse();
    start(1, 3);
    in_target_pill_num   = 6'd5;
    in_target_bottle_num = 6'd9;
    pulse();
    pulse();
    exp_q.push_back({6'd1, 12'd3});
    pulse();
    checks++;
    if (out_cur_pills !== 6'd3 || out_valve_open !== 1'b0 || out_state !== 2'b01) begin
      failures++;
      $display("FAIL tgt_latched: cur=%0d valve=%b state=%b, required 3/0/01",
               out_cur_pills, out_valve_open, out_state);
    end
    ready2();
    checks++;
    if (out_state !== 2'b11 || out_done_bottles !== 6'd1) begin
      failures++;
      $display("FAIL tgt_latched_report: state=%b done=%0d, required 11/1", out_state, out_done_bottles);
    end
    $display("target_change: done=%0d state=%b", out_done_bottles, out_state);
  endtask

  task automatic test_drain();
    tick(2);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected advances never seen, required 0", exp_q.size());
    end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_fill_2x3();
    test_zero_target();
    test_overfill();
    test_full_63();
    test_clear_mid();
    test_reset_mid();
    test_target_change();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
